// File: rtl/dmemory_banked_if.sv
// Request/response bus of the byte-addressable banked data memory.
// The master drives requests; the memory answers with ready and registered read data.
interface dmemory_banked_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    localparam int NB = DATA_W / 8;

    logic              req;
    logic              we;
    logic [NB-1:0]     byte_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              clear;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, byte_en, addr, wdata, clear,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, byte_en, addr, wdata, clear,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/dmemory_banked.sv
// Word-organised data memory with byte lanes, unaligned access split over two cycles,
// and a word-by-word initialisation sweep after reset or on clear.
module dmemory_banked #(
    parameter int                 DATA_W    = 16,
    parameter int                 ADDR_W    = 16,
    parameter logic [DATA_W-1:0]  INIT_WORD = 16'hABCD
) (
    input  logic             clk,
    input  logic             rst_n,
    dmemory_banked_if.slave  bus
);
    localparam int NB    = DATA_W / 8;
    localparam int LW    = $clog2(NB);
    localparam int OW    = (LW > 0) ? LW : 1;
    localparam int WA_W  = ADDR_W - LW;
    localparam int WORDS = 1 << WA_W;
    localparam logic [WA_W-1:0] LAST = WA_W'(WORDS - 1);

    typedef logic [NB-1:0][7:0] word_t;
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_SPLIT} state_t;

    word_t mem [WORDS];

    state_t           state_q, state_d;
    logic [WA_W-1:0]  cnt_q, cnt_d;
    logic [WA_W-1:0]  w0_q, w0_d;
    logic [OW-1:0]    off_q, off_d;
    logic             we_q, we_d;
    logic [NB-1:0]    be_q, be_d;
    word_t            wdata_q, wdata_d;
    word_t            rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    logic [WA_W-1:0]  mem_wa;
    word_t            mem_wd;
    logic [NB-1:0]    mem_be;
    logic [WA_W-1:0]  req_w0;
    logic [OW-1:0]    req_off;
    word_t            wd_in;

    assign req_w0  = bus.addr[ADDR_W-1:LW];
    assign req_off = (LW > 0) ? bus.addr[OW-1:0] : '0;
    assign wd_in   = bus.wdata;

    // Lane k of the result is byte (off+k) of the lo word, spilling into the hi word.
    function automatic word_t assemble(input word_t lo, input word_t hi, input logic [OW-1:0] off);
        word_t r;
        r = '0;
        for (int k = 0; k < NB; k++) begin
            if (k + int'(off) < NB) r[k] = lo[k + int'(off)];
            else                    r[k] = hi[k + int'(off) - NB];
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        w0_d     = w0_q;
        off_d    = off_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        mem_wa   = w0_q;
        mem_wd   = '0;
        mem_be   = '0;
        case (state_q)
            S_INIT: begin
                mem_wa = cnt_q;
                mem_wd = (cnt_q == '0) ? INIT_WORD : '0;
                mem_be = '1;
                if (cnt_q == LAST) state_d = S_IDLE;
                else               cnt_d   = cnt_q + 1'b1;
            end
            S_IDLE: begin
                if (bus.clear) begin
                    state_d = S_INIT;
                end else if (bus.req) begin
                    w0_d    = req_w0;
                    off_d   = req_off;
                    we_d    = bus.we;
                    be_d    = bus.byte_en;
                    wdata_d = wd_in;
                    mem_wa  = req_w0;
                    if (bus.we) begin
                        // First word holds positions off..NB-1, fed from lanes 0..NB-1-off.
                        for (int p = 0; p < NB; p++) begin
                            if (p >= int'(req_off)) begin
                                mem_wd[p] = wd_in[p - int'(req_off)];
                                mem_be[p] = bus.byte_en[p - int'(req_off)];
                            end
                        end
                    end else if (req_off == '0) begin
                        rdata_d  = mem[req_w0];
                        rvalid_d = 1'b1;
                    end
                    if (req_off != '0) state_d = S_SPLIT;
                end
            end
            S_SPLIT: begin
                state_d = S_IDLE;
                mem_wa  = w0_q + 1'b1;
                if (we_q) begin
                    for (int p = 0; p < NB; p++) begin
                        if (p < int'(off_q)) begin
                            mem_wd[p] = wdata_q[p + NB - int'(off_q)];
                            mem_be[p] = be_q[p + NB - int'(off_q)];
                        end
                    end
                end else begin
                    rdata_d  = assemble(mem[w0_q], mem[mem_wa], off_q);
                    rvalid_d = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            w0_q     <= '0;
            off_q    <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w0_q     <= w0_d;
            off_q    <= off_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Storage carries no reset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NB; p++) begin
            if (mem_be[p]) mem[mem_wa][p] <= mem_wd[p];
        end
    end

    assign bus.ready  = (state_q == S_IDLE);
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_dmemory_banked.sv
// Directed and randomized checks of dmemory_banked against a flat byte-array model.
module tb_dmemory_banked;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] mref [64];
  logic [15:0] last_rd = '0;
  logic [15:0] rd;
  int cyc;

  dmemory_banked_if #(.DATA_W(16), .ADDR_W(6)) bus ();
  dmemory_banked #(.DATA_W(16), .ADDR_W(6), .INIT_WORD(16'hABCD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < 64; i++) mref[i] = 8'h00;
    mref[0] = 8'hCD;
    mref[1] = 8'hAB;
  endtask

  function automatic logic [15:0] model_rd(input int a);
    return {mref[(a + 1) % 64], mref[a % 64]};
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic acc(input bit w, input int a, input logic [15:0] d, input logic [1:0] be,
                     output logic [15:0] r);
    int n;
    logic [15:0] exp;
    bit mis;
    wait_ready(n);
    check("acc_ready", bus.ready, 1);
    bus.req = 1'b1; bus.we = w; bus.addr = 6'(a); bus.wdata = d; bus.byte_en = be;
    @(negedge clk);
    bus.req = 1'b0; bus.we = 1'b0;
    mis = (a % 2) != 0;
    r = last_rd;
    if (w) begin
      if (be[0]) mref[a % 64] = d[7:0];
      if (be[1]) mref[(a + 1) % 64] = d[15:8];
      check("wr_rvalid", bus.rvalid, 0);
      check("wr_hold", bus.rdata, last_rd);
      if (mis) begin
        check("wr_split_rdy", bus.ready, 0);
        @(negedge clk);
        check("wr_split_rvalid", bus.rvalid, 0);
      end
      check("wr_done_rdy", bus.ready, 1);
    end else begin
      exp = model_rd(a);
      if (mis) begin
        check("rd_split_rdy", bus.ready, 0);
        check("rd_split_early", bus.rvalid, 0);
        @(negedge clk);
      end
      check("rd_valid", bus.rvalid, 1);
      check("rd_data", bus.rdata, exp);
      last_rd = exp;
      r = bus.rdata;
      @(negedge clk);
      check("rd_pulse", bus.rvalid, 0);
      check("rd_hold", bus.rdata, exp);
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.byte_en = '0; bus.addr = '0;
    bus.wdata = '0; bus.clear = 1'b0;
    model_init();
    #1;
    check("rst_ready", bus.ready, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rdata", bus.rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(cyc);
    check("sweep_len", cyc, 32);

    acc(0, 0, 0, 0, rd);            check("init_w0", rd, 16'hABCD);
    acc(0, 2, 0, 0, rd);            check("init_w1", rd, 16'h0000);
    acc(1, 4, 16'h1234, 2'b11, rd);
    acc(0, 4, 0, 0, rd);            check("wr_full", rd, 16'h1234);
    acc(1, 4, 16'hFF77, 2'b01, rd);
    acc(0, 4, 0, 0, rd);            check("wr_lane0", rd, 16'h1277);
    acc(1, 5, 16'hBEEF, 2'b11, rd);
    acc(0, 4, 0, 0, rd);            check("mis_lo", rd, 16'hEF77);
    acc(0, 6, 0, 0, rd);            check("mis_hi", rd, 16'h00BE);
    acc(0, 5, 0, 0, rd);            check("mis_rd", rd, 16'hBEEF);
    acc(1, 63, 16'h5AA5, 2'b11, rd);
    acc(0, 0, 0, 0, rd);            check("wrap_w0", rd, 16'hAB5A);
    acc(0, 63, 0, 0, rd);           check("wrap_rd", rd, 16'h5AA5);

    // Clear beats a simultaneous write.
    bus.clear = 1'b1; bus.req = 1'b1; bus.we = 1'b1; bus.addr = 6'd8;
    bus.wdata = 16'h1111; bus.byte_en = 2'b11;
    @(negedge clk);
    bus.clear = 1'b0; bus.req = 1'b0; bus.we = 1'b0;
    check("clr_ready", bus.ready, 0);
    model_init();
    wait_ready(cyc);
    check("clr_sweep_len", cyc, 32);
    acc(0, 8, 0, 0, rd);            check("clr_no_wr", rd, 16'h0000);
    acc(0, 0, 0, 0, rd);            check("clr_w0", rd, 16'hABCD);

    for (int i = 0; i < 80; i++) begin
      acc(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 16'($urandom),
          2'($urandom_range(0, 3)), rd);
    end
    acc(0, 0, 0, 0, rd);

    // Reset in the middle of a sweep.
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", bus.ready, 0);
    check("mid_rst_rvalid", bus.rvalid, 0);
    check("mid_rst_rdata", bus.rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
    last_rd = '0;
    wait_ready(cyc);
    check("mid_rst_sweep", cyc, 32);
    acc(0, 0, 0, 0, rd);            check("mid_rst_w0", rd, 16'hABCD);
    acc(0, 2, 0, 0, rd);            check("mid_rst_w1", rd, 16'h0000);

    // Reset while the second half of a split read is pending.
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 6'd1;
    @(posedge clk);
    #2;
    bus.req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("split_rst_ready", bus.ready, 0);
    check("split_rst_rvalid", bus.rvalid, 0);
    check("split_rst_rdata", bus.rdata, 0);
    @(negedge clk);
    check("split_abandon", bus.rvalid, 0);
    rst_n = 1'b1;
    model_init();
    last_rd = '0;
    wait_ready(cyc);
    check("split_rst_sweep", cyc, 32);
    acc(0, 1, 0, 0, rd);            check("post_rst_mis", rd, 16'h00AB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
